// File: rtl/segasys1_pkg.sv
// Shared types for the System 1 program-ROM arbiter: FSM states and owner tags.
package segasys1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } arbState_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // A zero limit still needs one bit so the counter port never collapses.
    function automatic int cntWidth(input int lim);
        return (lim < 1) ? 1 : $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/segasys1_rdpipe.sv
// Two-stage owner/valid pipeline tracking ROM reads in flight; steers the
// returned ROM byte to the owning requester and pulses its acknowledge.
module segasys1_rdpipe
    import segasys1_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_grant,
    input  owner_t        i_owner,
    input  logic [DW-1:0] i_rdt,
    output logic          o_v0,
    output logic          o_v1,
    output owner_t        o_own0,
    output owner_t        o_own1,
    output logic          o_aAck,
    output logic          o_aDt_unused_guard,
    output logic [DW-1:0] o_aDt,
    output logic          o_bAck,
    output logic [DW-1:0] o_bDt
);

    logic          r_v0;
    logic          r_v1;
    owner_t        r_own0;
    owner_t        r_own1;
    logic          r_aAck;
    logic          r_bAck;
    logic [DW-1:0] r_aDt;
    logic [DW-1:0] r_bDt;
    logic          w_capA;
    logic          w_capB;

    // Stage 1 lines up with the cycle in which the synchronous ROM presents data.
    assign w_capA = r_v1 && (r_own1 == OWN_A);
    assign w_capB = r_v1 && (r_own1 == OWN_B);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_own0 <= OWN_A;
            r_own1 <= OWN_A;
            r_aAck <= 1'b0;
            r_bAck <= 1'b0;
            r_aDt  <= '0;
            r_bDt  <= '0;
        end else begin
            r_v0   <= i_grant;
            r_own0 <= i_owner;
            r_v1   <= r_v0;
            r_own1 <= r_own0;
            r_aAck <= w_capA;
            r_bAck <= w_capB;
            if (w_capA) begin
                r_aDt <= i_rdt;
            end
            if (w_capB) begin
                r_bDt <= i_rdt;
            end
        end
    end

    assign o_v0   = r_v0;
    assign o_v1   = r_v1;
    assign o_own0 = r_own0;
    assign o_own1 = r_own1;
    assign o_aAck = r_aAck;
    assign o_bAck = r_bAck;
    assign o_aDt  = r_aDt;
    assign o_bDt  = r_bDt;
    assign o_aDt_unused_guard = r_aAck && r_bAck;

endmodule

// File: rtl/segasys1_romarb.sv
// Program-ROM arbiter: two level-request ports share one synchronous ROM,
// one read per clock, A-priority with a starvation limit for B.
module segasys1_romarb
    import segasys1_pkg::*;
#(
    parameter int AW   = 15,
    parameter int DW   = 8,
    parameter int BLIM = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_busy,
    input  logic          a_req,
    input  logic [AW-1:0] a_ad,
    output logic [DW-1:0] a_dt,
    output logic          a_ack,
    input  logic          b_req,
    input  logic [AW-1:0] b_ad,
    output logic [DW-1:0] b_dt,
    output logic          b_ack,
    output logic [AW-1:0] rad,
    input  logic [DW-1:0] rdt
);

    localparam int            CW  = cntWidth(BLIM);
    localparam logic [CW-1:0] LIM = CW'(BLIM);

    arbState_t     r_state;
    arbState_t     w_nextState;
    logic [CW-1:0] r_starve;
    logic          r_lastA;
    logic [AW-1:0] r_rad;

    logic   w_v0;
    logic   w_v1;
    owner_t w_own0;
    owner_t w_own1;
    logic   w_bothAck;
    logic   w_aElig;
    logic   w_bElig;
    logic   w_bFirst;
    logic   w_grantEn;
    logic   w_grantA;
    logic   w_grantB;
    logic   w_grant;
    owner_t w_owner;

    segasys1_rdpipe #(.DW(DW)) u_rdpipe (
        .clk                (clk),
        .reset              (reset),
        .i_grant            (w_grant),
        .i_owner            (w_owner),
        .i_rdt              (rdt),
        .o_v0               (w_v0),
        .o_v1               (w_v1),
        .o_own0             (w_own0),
        .o_own1             (w_own1),
        .o_aAck             (a_ack),
        .o_aDt_unused_guard (w_bothAck),
        .o_aDt              (a_dt),
        .o_bAck             (b_ack),
        .o_bDt              (b_dt)
    );

    // One outstanding read per requester; the ack cycle also blocks re-issue
    // because a level request is still high while its ack is being seen.
    assign w_aElig = a_req && !a_ack
                   && !(w_v0 && (w_own0 == OWN_A))
                   && !(w_v1 && (w_own1 == OWN_A));
    assign w_bElig = b_req && !b_ack
                   && !(w_v0 && (w_own0 == OWN_B))
                   && !(w_v1 && (w_own1 == OWN_B));

    // With a zero limit B priority simply alternates with the last winner.
    assign w_bFirst = (BLIM == 0) ? r_lastA : (r_starve == LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (dl_busy) begin
            w_nextState = HOLD;
        end else begin
            case (r_state)
                IDLE: if (w_grant) w_nextState = BUSY;
                BUSY: if (!w_grant && !w_v0) w_nextState = IDLE;
                HOLD: if (!w_v0 && !w_v1) w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        w_grantEn = (r_state != HOLD) && !dl_busy;
        w_grantA  = w_grantEn && w_aElig && (!w_bElig || !w_bFirst);
        w_grantB  = w_grantEn && w_bElig && (!w_aElig || w_bFirst);
        w_grant   = w_grantA || w_grantB;
        w_owner   = w_grantB ? OWN_B : OWN_A;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rad    <= '0;
            r_starve <= '0;
            r_lastA  <= 1'b0;
        end else begin
            if (w_grantA) begin
                r_rad   <= a_ad;
                r_lastA <= 1'b1;
            end else if (w_grantB) begin
                r_rad   <= b_ad;
                r_lastA <= 1'b0;
            end
            if (w_grantB || !w_bElig) begin
                r_starve <= '0;
            end else if (w_grantA && (r_starve != LIM)) begin
                r_starve <= r_starve + CW'(1);
            end
        end
    end

    assign rad = r_rad;

endmodule

// File: tb/tb_segasys1_romarb.sv
// Directed bench for segasys1_romarb with a behavioural synchronous ROM.
module tb_segasys1_romarb;
    import segasys1_pkg::*;

    logic        clk;
    logic        reset;
    logic        dl_busy;
    logic        a_req;
    logic [14:0] a_ad;
    logic [7:0]  a_dt;
    logic        a_ack;
    logic        b_req;
    logic [14:0] b_ad;
    logic [7:0]  b_dt;
    logic        b_ack;
    logic [14:0] rad;
    logic [7:0]  rdt;

    int tests;
    int failed;

    typedef struct {
        logic        aReq;
        logic [14:0] aAd;
        logic        bReq;
        logic [14:0] bAd;
        logic        dl;
        logic [14:0] expRad;
        logic        expAAck;
        logic [7:0]  expADt;
        logic        expBAck;
        logic [7:0]  expBDt;
        arbState_t   expState;
    } vec_t;

    vec_t vecs[22];

    segasys1_romarb #(.AW(15), .DW(8), .BLIM(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .dl_busy (dl_busy),
        .a_req   (a_req),
        .a_ad    (a_ad),
        .a_dt    (a_dt),
        .a_ack   (a_ack),
        .b_req   (b_req),
        .b_ad    (b_ad),
        .b_dt    (b_dt),
        .b_ack   (b_ack),
        .rad     (rad),
        .rdt     (rdt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] romVal(input logic [14:0] a);
        case (a)
            15'h0123: return 8'h5A;
            15'h0000: return 8'h11;
            15'h7FFF: return 8'hEE;
            default:  return 8'(32'(a) * 37 + 5);
        endcase
    endfunction

    // Synchronous ROM: registers rad, data valid one clock later.
    initial rdt = 8'h00;
    always @(posedge clk) rdt <= romVal(rad);

    function automatic vec_t mk(input logic aR, input logic [14:0] aA,
                                input logic bR, input logic [14:0] bA,
                                input logic d, input logic [14:0] eR,
                                input logic eAA, input logic [7:0] eAD,
                                input logic eBA, input logic [7:0] eBD,
                                input arbState_t eS);
        vec_t v;
        v.aReq = aR; v.aAd = aA; v.bReq = bR; v.bAd = bA; v.dl = d;
        v.expRad = eR; v.expAAck = eAA; v.expADt = eAD;
        v.expBAck = eBA; v.expBDt = eBD; v.expState = eS;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        a_req   = v.aReq;
        a_ad    = v.aAd;
        b_req   = v.bReq;
        b_ad    = v.bAd;
        dl_busy = v.dl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failed++;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] r42, r101, r203;
        int aAcks, bAcks, both, maxStarve, firstB, bAckCount;

        tests = 0;
        failed = 0;
        r42  = romVal(15'h0042);
        r101 = romVal(15'h0101);
        r203 = romVal(15'h0203);

        //            aR aAd       bR bAd       dl rad       aAck aDt    bAck bDt    state
        vecs[0]  = mk(1, 15'h0123, 0, 15'h0000, 0, 15'h0123, 0, 8'h00, 0, 8'h00, BUSY);
        vecs[1]  = mk(1, 15'h0123, 0, 15'h0000, 0, 15'h0123, 0, 8'h00, 0, 8'h00, BUSY);
        vecs[2]  = mk(1, 15'h0123, 0, 15'h0000, 0, 15'h0123, 1, 8'h5A, 0, 8'h00, IDLE);
        vecs[3]  = mk(0, 15'h0123, 0, 15'h0000, 0, 15'h0123, 0, 8'h5A, 0, 8'h00, IDLE);
        vecs[4]  = mk(1, 15'h0000, 1, 15'h7FFF, 0, 15'h0000, 0, 8'h5A, 0, 8'h00, BUSY);
        vecs[5]  = mk(1, 15'h0000, 1, 15'h7FFF, 0, 15'h7FFF, 0, 8'h5A, 0, 8'h00, BUSY);
        vecs[6]  = mk(1, 15'h0000, 1, 15'h7FFF, 0, 15'h7FFF, 1, 8'h11, 0, 8'h00, BUSY);
        vecs[7]  = mk(0, 15'h0000, 1, 15'h7FFF, 0, 15'h7FFF, 0, 8'h11, 1, 8'hEE, IDLE);
        vecs[8]  = mk(0, 15'h0000, 0, 15'h7FFF, 0, 15'h7FFF, 0, 8'h11, 0, 8'hEE, IDLE);
        vecs[9]  = mk(1, 15'h0042, 0, 15'h0000, 0, 15'h0042, 0, 8'h11, 0, 8'hEE, BUSY);
        vecs[10] = mk(0, 15'h0042, 0, 15'h0000, 0, 15'h0042, 0, 8'h11, 0, 8'hEE, BUSY);
        vecs[11] = mk(0, 15'h0042, 0, 15'h0000, 0, 15'h0042, 1, r42,   0, 8'hEE, IDLE);
        vecs[12] = mk(0, 15'h0042, 0, 15'h0000, 0, 15'h0042, 0, r42,   0, 8'hEE, IDLE);
        vecs[13] = mk(1, 15'h0101, 0, 15'h0000, 0, 15'h0101, 0, r42,   0, 8'hEE, BUSY);
        vecs[14] = mk(1, 15'h0101, 1, 15'h0203, 1, 15'h0101, 0, r42,   0, 8'hEE, HOLD);
        vecs[15] = mk(1, 15'h0101, 1, 15'h0203, 1, 15'h0101, 1, r101,  0, 8'hEE, HOLD);
        vecs[16] = mk(0, 15'h0101, 1, 15'h0203, 1, 15'h0101, 0, r101,  0, 8'hEE, HOLD);
        vecs[17] = mk(0, 15'h0101, 1, 15'h0203, 0, 15'h0101, 0, r101,  0, 8'hEE, IDLE);
        vecs[18] = mk(0, 15'h0101, 1, 15'h0203, 0, 15'h0203, 0, r101,  0, 8'hEE, BUSY);
        vecs[19] = mk(0, 15'h0101, 1, 15'h0203, 0, 15'h0203, 0, r101,  0, 8'hEE, BUSY);
        vecs[20] = mk(0, 15'h0101, 1, 15'h0203, 0, 15'h0203, 0, r101,  1, r203,  IDLE);
        vecs[21] = mk(0, 15'h0101, 0, 15'h0203, 0, 15'h0203, 0, r101,  0, r203,  IDLE);

        reset = 1'b1;
        dl_busy = 1'b0;
        a_req = 1'b0; a_ad = '0;
        b_req = 1'b0; b_ad = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset rad",    32'(rad),   32'h0);
        checkOutput("reset a_dt",   32'(a_dt),  32'h0);
        checkOutput("reset b_dt",   32'(b_dt),  32'h0);
        checkOutput("reset a_ack",  32'(a_ack), 32'h0);
        checkOutput("reset b_ack",  32'(b_ack), 32'h0);
        checkOutput("reset state",  32'(dut.r_state), 32'(IDLE));
        checkOutput("reset starve", 32'(dut.r_starve), 32'h0);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("row%0d rad", i),   32'(rad),   32'(vecs[i].expRad));
            checkOutput($sformatf("row%0d a_ack", i), 32'(a_ack), 32'(vecs[i].expAAck));
            checkOutput($sformatf("row%0d a_dt", i),  32'(a_dt),  32'(vecs[i].expADt));
            checkOutput($sformatf("row%0d b_ack", i), 32'(b_ack), 32'(vecs[i].expBAck));
            checkOutput($sformatf("row%0d b_dt", i),  32'(b_dt),  32'(vecs[i].expBDt));
            checkOutput($sformatf("row%0d state", i), 32'(dut.r_state), 32'(vecs[i].expState));
        end

        // Both requesters held high continuously for 20 clocks.
        aAcks = 0; bAcks = 0; both = 0; maxStarve = 0; firstB = -1;
        a_req = 1'b1; a_ad = 15'h0010;
        b_req = 1'b1; b_ad = 15'h0020;
        dl_busy = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (a_ack) aAcks++;
            if (b_ack) begin
                bAcks++;
                if (firstB < 0) firstB = c;
            end
            if (a_ack && b_ack) both++;
            if (int'(dut.r_starve) > maxStarve) maxStarve = int'(dut.r_starve);
        end
        a_req = 1'b0;
        b_req = 1'b0;
        checkOutput("contend a acks",     32'(aAcks), 32'd5);
        checkOutput("contend b acks",     32'(bAcks), 32'd5);
        checkOutput("contend ack overlap", 32'(both), 32'd0);
        checkOutput("contend starve<=BLIM", 32'(maxStarve <= 4), 32'd1);
        checkOutput("contend b ack bound", 32'((firstB >= 0) && (firstB < 10)), 32'd1);
        checkOutput("contend a_dt", 32'(a_dt), 32'(romVal(15'h0010)));
        checkOutput("contend b_dt", 32'(b_dt), 32'(romVal(15'h0020)));
        repeat (4) @(negedge clk);

        // Reset one clock after a B grant discards the read.
        b_req = 1'b1;
        b_ad = 15'h0300;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstmid grant rad", 32'(rad), 32'h0300);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        b_req = 1'b0;
        #1;
        checkOutput("rstmid async rad", 32'(rad), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bAckCount = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_ack) bAckCount++;
        end
        checkOutput("rstmid b_ack count", 32'(bAckCount), 32'd0);
        checkOutput("rstmid rad",   32'(rad),   32'h0);
        checkOutput("rstmid a_dt",  32'(a_dt),  32'h0);
        checkOutput("rstmid b_dt",  32'(b_dt),  32'h0);
        checkOutput("rstmid a_ack", 32'(a_ack), 32'h0);
        checkOutput("rstmid state", 32'(dut.r_state), 32'(IDLE));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
